// File: rtl/bus_matrix.sv
// N-source / M-destination bus mux with bus-hold, conflict and timeout tracking,
// and a ready/stall write handshake. Define BUS_MATRIX_STRICT_EN to blank the bus on conflicts.
module bus_matrix #(
    parameter int DATA_W    = 8,
    parameter int N_SRC     = 4,
    parameter int N_DST     = 6,
    parameter int CNT_W     = 4,
    parameter int STALL_MAX = 15
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [N_SRC*DATA_W-1:0] i_srcData,
    input  logic [N_SRC-1:0]        i_srcOe,
    input  logic [N_DST-1:0]        i_dstWr,
    input  logic [N_DST-1:0]        i_dstReady,
    input  logic                    i_errClear,
    output logic [DATA_W-1:0]       o_bus,
    output logic [N_DST-1:0]        o_dstWr,
    output logic                    o_stall,
    output logic                    o_conflict,
    output logic                    o_timeout,
    output logic [CNT_W-1:0]        o_errCount
);
    typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;

    localparam int SCW = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    state_t           state, stateNext;
    logic [SCW-1:0]   stallCnt, stallCntNext;
    logic [DATA_W-1:0] holdReg, busSel;
    logic             anyOe, multiOe, readyAll, stallReq, abortEntry;
    logic             holdLoad, wrBlock;

    // Lowest-index enabled source wins; with no enables the hold register drives the bus.
    always_comb begin
        busSel = holdReg;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (i_srcOe[k]) busSel = i_srcData[k*DATA_W +: DATA_W];
        end
    end

    assign anyOe    = |i_srcOe;
    assign multiOe  = |(i_srcOe & (i_srcOe - N_SRC'(1)));
    assign readyAll = &(~i_dstWr | i_dstReady);

`ifdef BUS_MATRIX_STRICT_EN
    assign o_bus    = multiOe ? '0 : busSel;
    assign holdLoad = anyOe & ~multiOe;
    assign wrBlock  = multiOe;
`else
    assign o_bus    = busSel;
    assign holdLoad = anyOe;
    assign wrBlock  = 1'b0;
`endif

    assign stallReq = (|i_dstWr) & ~readyAll & (state != ABORT);
    assign o_stall  = stallReq;
    assign o_dstWr  = (readyAll && state != ABORT && !wrBlock) ? i_dstWr : '0;

    always_comb begin
        stateNext    = state;
        stallCntNext = stallCnt;
        abortEntry   = 1'b0;
        case (state)
            IDLE: begin
                if (stallReq) begin
                    stateNext    = WAIT;
                    stallCntNext = SCW'(1);
                end
            end
            WAIT: begin
                if (readyAll || i_dstWr == '0) begin
                    stateNext    = IDLE;
                    stallCntNext = '0;
                end else if (stallCnt == SCW'(STALL_MAX)) begin
                    stateNext    = ABORT;
                    stallCntNext = '0;
                    abortEntry   = 1'b1;
                end else begin
                    stallCntNext = stallCnt + SCW'(1);
                end
            end
            ABORT: begin
                stateNext    = IDLE;
                stallCntNext = '0;
            end
            default: begin
                stateNext    = IDLE;
                stallCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            stallCnt   <= '0;
            holdReg    <= '0;
            o_conflict <= 1'b0;
            o_timeout  <= 1'b0;
            o_errCount <= '0;
        end else begin
            state    <= stateNext;
            stallCnt <= stallCntNext;
            if (holdLoad) holdReg <= o_bus;
            // Clear wins over any increment arriving in the same cycle.
            if (i_errClear) begin
                o_conflict <= 1'b0;
                o_timeout  <= 1'b0;
                o_errCount <= '0;
            end else begin
                if (multiOe)    o_conflict <= 1'b1;
                if (abortEntry) o_timeout  <= 1'b1;
                o_errCount <= satAdd(o_errCount, {1'b0, multiOe} + {1'b0, abortEntry});
            end
        end
    end
endmodule

// File: tb/tb_bus_matrix.sv
// Directed bench for bus_matrix: a cycle-level behavioural model checked every
// negative edge, plus hand-computed literal expectations for each scenario.
module tb_bus_matrix;
    localparam int DATA_W    = 8;
    localparam int N_SRC     = 4;
    localparam int N_DST     = 6;
    localparam int CNT_W     = 4;
    localparam int STALL_MAX = 15;
    localparam int ERR_MAX   = (1 << CNT_W) - 1;
`ifdef BUS_MATRIX_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_SRC*DATA_W-1:0] srcData;
    logic [N_SRC-1:0]        srcOe;
    logic [N_DST-1:0]        dstWr, dstReady;
    logic                    errClear;
    logic [DATA_W-1:0]       bus;
    logic [N_DST-1:0]        dstWrQ;
    logic                    stall, conflict, timeout;
    logic [CNT_W-1:0]        errCount;

    int nChecks = 0;
    int nFail   = 0;
    bit run     = 1'b0;

    bus_matrix #(.DATA_W(DATA_W), .N_SRC(N_SRC), .N_DST(N_DST), .CNT_W(CNT_W),
                 .STALL_MAX(STALL_MAX)) dut (
        .i_clk(clk), .i_reset(rst), .i_srcData(srcData), .i_srcOe(srcOe),
        .i_dstWr(dstWr), .i_dstReady(dstReady), .i_errClear(errClear),
        .o_bus(bus), .o_dstWr(dstWrQ), .o_stall(stall), .o_conflict(conflict),
        .o_timeout(timeout), .o_errCount(errCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: hold value, sticky flags, error count, consecutive stalled cycles, abort cycle.
    int mHold = 0, mErr = 0, mRun = 0;
    bit mConf = 0, mTo = 0, mAbort = 0;

    function automatic void modelComb(output logic [DATA_W-1:0] eBus, output logic [N_DST-1:0] eWr,
                                      output logic eStall, output bit isConf);
        int  nOe, low;
        bit  allReady, blank;
        nOe = $countones(srcOe);
        low = -1;
        for (int k = 0; k < N_SRC; k++) if (srcOe[k] && low < 0) low = k;
        allReady = ((dstWr & ~dstReady) == '0);
        isConf   = (nOe >= 2);
        blank    = STRICT && isConf;
        if (nOe == 0)   eBus = DATA_W'(mHold);
        else if (blank) eBus = '0;
        else            eBus = srcData[low*DATA_W +: DATA_W];
        eStall = (dstWr != '0) && !allReady && !mAbort;
        eWr    = (allReady && !mAbort && !blank) ? dstWr : '0;
    endfunction

    always @(posedge clk) begin
        logic [DATA_W-1:0] eBus;
        logic [N_DST-1:0]  eWr;
        logic              eStall;
        bit                isConf, abortNext;
        modelComb(eBus, eWr, eStall, isConf);
        if (rst) begin
            mHold = 0; mErr = 0; mRun = 0; mConf = 0; mTo = 0; mAbort = 0;
        end else begin
            abortNext = eStall && (mRun == STALL_MAX);
            mRun      = (eStall && !abortNext) ? mRun + 1 : 0;
            mAbort    = abortNext;
            if (srcOe != '0 && !(STRICT && isConf)) mHold = int'(eBus);
            if (errClear) begin
                mConf = 0; mTo = 0; mErr = 0;
            end else begin
                if (isConf)    mConf = 1;
                if (abortNext) mTo = 1;
                mErr = mErr + int'(isConf) + int'(abortNext);
                if (mErr > ERR_MAX) mErr = ERR_MAX;
            end
        end
    end

    always @(negedge clk) begin
        logic [DATA_W-1:0] eBus;
        logic [N_DST-1:0]  eWr;
        logic              eStall;
        bit                isConf;
        if (run) begin
            modelComb(eBus, eWr, eStall, isConf);
            chk("model bus", bus, eBus);
            chk("model dstWr", dstWrQ, eWr);
            chk("model stall", stall, eStall);
            chk("model conflict", conflict, mConf);
            chk("model timeout", timeout, mTo);
            chk("model errCount", errCount, mErr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setSrc(input int k, input logic [DATA_W-1:0] v);
        srcData[k*DATA_W +: DATA_W] = v;
    endtask

    // Count consecutive stalled cycles (bounded); returns positioned inside the first non-stall cycle.
    task automatic countStall(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall) return;
            n++;
            @(posedge clk);
            #0;
        end
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; srcData = '0; srcOe = '0; dstWr = '0; dstReady = '1; errClear = 1'b0;
        tick();
        run = 1'b1;
        #1;
        chk("reset bus", bus, 8'h00);
        chk("reset conflict", conflict, 1'b0);
        chk("reset timeout", timeout, 1'b0);
        chk("reset errCount", errCount, 4'd0);
        chk("reset stall", stall, 1'b0);
        tick();
        rst = 1'b0;

        // Single source drives the bus, then the hold register keeps it.
        setSrc(1, 8'hA5); srcOe = 4'b0010;
        #1; chk("t1 bus direct", bus, 8'hA5);
        tick(); srcOe = 4'b0000;
        #1; chk("t1 bus hold", bus, 8'hA5);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        #1; chk("t1 bus after reset", bus, 8'h00);

        // Two sources enabled: conflict.
        tick();
        setSrc(1, 8'h11); setSrc(2, 8'h22); srcOe = 4'b0110; dstWr = 6'b000001;
        #1;
        chk("t2 bus", bus, STRICT ? 8'h00 : 8'h11);
        chk("t2 dstWr", dstWrQ, STRICT ? 6'b000000 : 6'b000001);
        tick(); srcOe = '0; dstWr = '0;
        #1;
        chk("t2 conflict", conflict, 1'b1);
        chk("t2 errCount", errCount, 4'd1);
        chk("t2 hold", bus, STRICT ? 8'h00 : 8'h11);
        errClear = 1'b1;
        tick(); errClear = 1'b0;
        #1; chk("t2 cleared", errCount, 4'd0);

        // Slow destination: three stall cycles then the write commits.
        tick();
        dstWr = 6'b000100; dstReady = 6'b111011;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3 stall", stall, 1'b1);
            chk("t3 no strobe", dstWrQ, 6'b000000);
            tick();
        end
        dstReady = 6'b111111;
        #1;
        chk("t3 release stall", stall, 1'b0);
        chk("t3 strobe", dstWrQ, 6'b000100);
        tick(); dstWr = '0;

        // Ready never arrives: 16 stall cycles, one abort cycle, timeout flagged.
        tick();
        dstWr = 6'b000100; dstReady = 6'b111011;
        countStall(n);
        chk("t4 stall cycles", n, 16);
        chk("t4 abort no strobe", dstWrQ, 6'b000000);
        tick(); dstWr = '0;
        #1;
        chk("t4 timeout", timeout, 1'b1);
        chk("t4 errCount", errCount, 4'd1);
        errClear = 1'b1;
        tick(); errClear = 1'b0;

        // Error counter saturation and clear priority.
        setSrc(0, 8'h3C); setSrc(1, 8'hC3); srcOe = 4'b0011;
        for (int i = 0; i < 20; i++) tick();
        #1;
        chk("t5 saturate", errCount, 4'd15);
        chk("t5 conflict", conflict, 1'b1);
        errClear = 1'b1;
        tick(); errClear = 1'b0; srcOe = '0;
        #1;
        chk("t5 clear count", errCount, 4'd0);
        chk("t5 clear flag", conflict, 1'b0);

        // Reset in the 5th stall cycle drops the write and restarts the stall timer.
        tick();
        dstWr = 6'b000100; dstReady = 6'b111011;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1; chk("t6 stall in reset", stall, 1'b1);
        tick(); rst = 1'b0;
        #1;
        chk("t6 stall after reset", stall, 1'b1);
        chk("t6 no strobe", dstWrQ, 6'b000000);
        chk("t6 bus reset", bus, 8'h00);
        countStall(n);
        chk("t6 restart stall cycles", n, 16);
        tick(); dstWr = '0; dstReady = '1;
        tick(); tick();

        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/bus_matrix.md
Name: bus_matrix

Overview:
Parametrised successor to the single shared 8-bit datapath bus. It replaces multi-driver bus assignment with an explicit N-source, M-destination mux. It adds a bus-hold register, conflict detection and a sticky error counter. It also adds a ready/stall handshake with timeout for slow destinations such as wait-state RAM. It sits between the control unit and the datapath units (ALU, register set, RAM, PC).

Parameters:
DATA_W, 8, bus width in bits
N_SRC, 4, number of bus sources (ALU, regs, RAM, PC in the base configuration)
N_DST, 6, number of bus destinations
CNT_W, 4, width of the saturating error counter
STALL_MAX, 15, maximum consecutive stall cycles before timeout (1..255)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_srcData  in  N_SRC*DATA_W  packed source data; source k occupies bits [k*DATA_W +: DATA_W]
i_srcOe  in  N_SRC  per-source output enable from control
i_dstWr  in  N_DST  per-destination write request from control
i_dstReady  in  N_DST  destination ready; 1 = accepts write this cycle
i_errClear  in  1  clears o_conflict, o_timeout and o_errCount
o_bus  out  DATA_W  resolved bus value; destinations take their data from here
o_dstWr  out  N_DST  qualified write strobes to destinations
o_stall  out  1  control must freeze its outputs while high
o_conflict  out  1  sticky: more than one source was enabled in some cycle
o_timeout  out  1  sticky: a stall reached STALL_MAX and the write was aborted
o_errCount  out  CNT_W  saturating count of conflict and timeout events

Behaviour:
- Reset is synchronous, active-high, one clock. On reset: hold register = 0, o_conflict = 0, o_timeout = 0, o_errCount = 0, FSM = IDLE, stall counter = 0.
- Bus resolution is combinational, zero latency:
  - exactly one i_srcOe bit set -> o_bus = that source;
  - no bits set -> o_bus = hold register;
  - two or more bits set -> lowest-index enabled source wins.
- Hold register: loads o_bus on every clock where any i_srcOe bit is set. Otherwise it keeps its value.
- Conflict: in a cycle with 2 or more i_srcOe bits set, o_conflict is set at the next edge and o_errCount increments by 1.
- Write readiness: ready_all = AND over j of (~i_dstWr[j] | i_dstReady[j]).
- o_dstWr = i_dstWr when ready_all = 1 and FSM is not ABORT; otherwise all zeros. Writes are all-or-nothing: no partial commit.
- o_stall = (|i_dstWr) & ~ready_all & (FSM != ABORT). It is combinational.
- FSM states: IDLE, WAIT, ABORT.
  - IDLE: if o_stall -> WAIT, stall counter = 1.
  - WAIT: if ready_all or i_dstWr == 0 -> IDLE. Else if stall counter == STALL_MAX -> ABORT. Else increment the stall counter.
  - ABORT: lasts exactly one cycle with o_stall = 0 and o_dstWr = 0, so control can advance. On entry, o_timeout is set and o_errCount increments. Then -> IDLE.
- Counter rules:
  - o_errCount saturates at 2^CNT_W-1.
  - A conflict and an ABORT entry in the same cycle increment by 2, saturating.
  - i_errClear has priority over a same-cycle increment: result is 0 and the flags clear.
- Reset mid-stall returns the FSM to IDLE. An outstanding write is dropped with no strobe.
- Source resolution continues normally during a stall; the hold register still updates.

Optional Feature:
BUS_MATRIX_STRICT_EN
- Defined: on a conflict cycle, o_bus = 0 instead of the lowest-index source; the hold register is not updated; o_dstWr is forced to 0 that cycle.
- Undefined: lowest-index-wins as described above.
- Conflict flag and counter behaviour are identical in both builds.

Test Plan:
1. Reset, then i_srcOe=0010 with src1=0xA5 -> o_bus=0xA5 the same cycle; next cycle i_srcOe=0 -> o_bus=0xA5 (hold); after reset o_bus=0x00.
2. i_srcOe=0110, src1=0x11, src2=0x22 -> o_bus=0x11, o_conflict=1 and o_errCount=1 next cycle. With STRICT: o_bus=0x00 and o_dstWr=0.
3. i_dstWr=000100 with i_dstReady[2]=0 for 3 cycles, then 1 -> o_stall=1 for 3 cycles, o_dstWr[2]=1 only in the 4th cycle, FSM back to IDLE.
4. STALL_MAX=15 with ready held low -> o_stall high for 16 cycles, then one ABORT cycle with o_stall=0 and o_dstWr=0; o_timeout=1, o_errCount=1.
5. 20 conflict cycles with CNT_W=4 -> o_errCount saturates at 15. Then i_errClear together with a further conflict -> o_errCount=0 and o_conflict=0.
6. i_reset asserted in the 5th cycle of a stall -> next cycle FSM=IDLE, o_stall follows ready_all, and no write strobe is emitted for the dropped write.
